// File: rtl/pc_unit.sv
// pc_unit: F-stage fetch-address unit. Owns the PC register, resolves
// D-stage branch conditions and targets, arbitrates reset / interrupt /
// stall / eret / jr / j / branch, flags illegal fetch addresses and keeps
// saturating redirect counters for performance debug.

// Saturating up-counter with synchronous clear; clear wins over increment.
module pc_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && ~&cnt_q)    cnt_d = cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module pc_unit #(
  parameter int          AW         = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES   = 32'h0000_1000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [AW-1:0]    pc4_d,
  input  logic [25:0]      imm26_d,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic [2:0]       br_type_d,
  input  logic             j_d,
  input  logic             jr_d,
  input  logic             eret_d,
  input  logic             int_req,
  input  logic [AW-1:0]    epc,
  input  logic             cnt_clr,
  output logic [AW-1:0]    pc_f,
  output logic [AW-1:0]    npc,
  output logic             taken_d,
  output logic             adel_f,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [CNT_W-1:0] int_cnt
);
  localparam logic [AW-1:0] RST_V = AW'(RESET_PC);
  localparam logic [AW-1:0] HDL_V = AW'(HANDLER_PC);
  // window bounds carried one bit wider so BASE+BYTES cannot wrap
  localparam logic [AW:0]   IM_LO = (AW+1)'(IM_BASE);
  localparam logic [AW:0]   IM_HI = (AW+1)'(IM_BASE) + (AW+1)'(IM_BYTES);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_BEQ  = 3'd1, BR_BNE  = 3'd2, BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4, BR_BLTZ = 3'd5, BR_BGEZ = 3'd6, BR_RSVD = 3'd7
  } br_e;

  // which priority rule produced npc this cycle
  typedef enum logic [2:0] {
    SEL_RST, SEL_INT, SEL_STALL, SEL_ERET, SEL_JR, SEL_J, SEL_BR, SEL_SEQ
  } sel_e;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] br_tgt, j_tgt, seq_pc;
  logic          br_cond;
  logic          rs_neg, rs_zero;
  sel_e          sel;

  assign rs_neg  = rs_d[AW-1];
  assign rs_zero = (rs_d == '0);

  // branch condition; the sign-compare kinds only look at rs
  always_comb begin
    br_cond = 1'b0;
    unique case (br_e'(br_type_d))
      BR_BEQ:  br_cond = (rs_d == rt_d);
      BR_BNE:  br_cond = (rs_d != rt_d);
      BR_BLEZ: br_cond = rs_neg | rs_zero;
      BR_BGTZ: br_cond = ~rs_neg & ~rs_zero;
      BR_BLTZ: br_cond = rs_neg;
      BR_BGEZ: br_cond = ~rs_neg;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_tgt = pc4_d + {{(AW-18){imm26_d[15]}}, imm26_d[15:0], 2'b00};
  assign j_tgt  = {pc4_d[AW-1:28], imm26_d, 2'b00};
  assign seq_pc = pc_q + AW'(4);

  // priority arbitration: reset > int > stall > eret > jr > j > branch > seq
  always_comb begin
    sel = SEL_SEQ;
    if (reset)        sel = SEL_RST;
    else if (int_req) sel = SEL_INT;
    else if (stall)   sel = SEL_STALL;
    else if (eret_d)  sel = SEL_ERET;
    else if (jr_d)    sel = SEL_JR;
    else if (j_d)     sel = SEL_J;
    else if (br_cond) sel = SEL_BR;
  end

  // next-PC mux driven by the selected rule
  always_comb begin
    pc_d = seq_pc;
    unique case (sel)
      SEL_RST:   pc_d = RST_V;
      SEL_INT:   pc_d = HDL_V;
      SEL_STALL: pc_d = pc_q;
      SEL_ERET:  pc_d = epc;
      SEL_JR:    pc_d = rs_d;
      SEL_J:     pc_d = j_tgt;
      SEL_BR:    pc_d = br_tgt;
      default:   pc_d = seq_pc;
    endcase
  end

  // fetch PC register; pc_d already folds in reset, this keeps it explicit
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RST_V;
    else       pc_q <= pc_d;
  end

  assign pc_f    = pc_q;
  assign npc     = pc_d;
  assign taken_d = (sel == SEL_ERET) | (sel == SEL_JR) |
                   (sel == SEL_J)    | (sel == SEL_BR);

  // fetch address check: misaligned or outside the instruction window
  assign adel_f = (pc_q[1:0] != 2'b00) ||
                  ({1'b0, pc_q} <  IM_LO) ||
                  ({1'b0, pc_q} >= IM_HI);

  // perf counters: eret returns are not counted as taken redirects
  logic [1:0]            ctr_inc;
  logic [1:0][CNT_W-1:0] ctr_val;

  assign ctr_inc[0] = taken_d & (sel != SEL_ERET);
  assign ctr_inc[1] = (sel == SEL_INT);

  for (genvar g = 0; g < 2; g++) begin : g_ctr
    pc_sat_ctr #(.W(CNT_W)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr),
      .inc_i (ctr_inc[g]),
      .cnt_o (ctr_val[g])
    );
  end

  assign br_taken_cnt = ctr_val[0];
  assign int_cnt      = ctr_val[1];
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: walks the reset, branch, jump, stall,
// interrupt/eret, address-check and counter-saturation scenarios with
// hand-computed expectations. A second instance with 4-bit counters
// shares all inputs and is used for the saturation checks.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, j_d, jr_d, eret_d, int_req, cnt_clr;
  logic [31:0] pc4_d, rs_d, rt_d, epc;
  logic [25:0] imm26_d;
  logic [2:0]  br_type_d;

  logic [31:0] pc_f, npc, pc_f_s, npc_s;
  logic        taken_d, adel_f, taken_s, adel_s;
  logic [15:0] br_cnt, int_cnt;
  logic [3:0]  br_cnt_s, int_cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc4_d(pc4_d), .imm26_d(imm26_d),
    .rs_d(rs_d), .rt_d(rt_d), .br_type_d(br_type_d), .j_d(j_d), .jr_d(jr_d),
    .eret_d(eret_d), .int_req(int_req), .epc(epc), .cnt_clr(cnt_clr),
    .pc_f(pc_f), .npc(npc), .taken_d(taken_d), .adel_f(adel_f),
    .br_taken_cnt(br_cnt), .int_cnt(int_cnt)
  );

  pc_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .pc4_d(pc4_d), .imm26_d(imm26_d),
    .rs_d(rs_d), .rt_d(rt_d), .br_type_d(br_type_d), .j_d(j_d), .jr_d(jr_d),
    .eret_d(eret_d), .int_req(int_req), .epc(epc), .cnt_clr(cnt_clr),
    .pc_f(pc_f_s), .npc(npc_s), .taken_d(taken_s), .adel_f(adel_s),
    .br_taken_cnt(br_cnt_s), .int_cnt(int_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    stall = 0; j_d = 0; jr_d = 0; eret_d = 0; int_req = 0; cnt_clr = 0;
    br_type_d = 3'd0; pc4_d = '0; rs_d = '0; rt_d = '0; epc = '0; imm26_d = '0;
  endtask

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    quiet();
    reset = 1;
    step();
    step();
    chk("rst_pc", pc_f, 32'h3000);
    chk("rst_npc", npc, 32'h3000);
    chk("rst_taken", {31'b0, taken_d}, 0);
    chk("rst_brcnt", {16'b0, br_cnt}, 0);
    chk("rst_intcnt", {16'b0, int_cnt}, 0);
    chk("rst_adel", {31'b0, adel_f}, 0);

    // sequential fetch
    reset = 0;
    #1 chk("seq_npc0", npc, 32'h3004);
    step(); chk("seq_pc1", pc_f, 32'h3004);
    step(); chk("seq_pc2", pc_f, 32'h3008);
    step(); chk("seq_pc3", pc_f, 32'h300C);
    chk("seq_adel", {31'b0, adel_f}, 0);

    // beq taken backward: 0x3008 + (-1<<2) = 0x3004
    br_type_d = 3'd1; rs_d = 5; rt_d = 5; pc4_d = 32'h3008; imm26_d = 26'hFFFF;
    #1 chk("beq_npc", npc, 32'h3004);
    chk("beq_taken", {31'b0, taken_d}, 1);
    step(); chk("beq_pc", pc_f, 32'h3004);
    chk("beq_cnt", {16'b0, br_cnt}, 1);

    // bne with equal operands: falls through
    br_type_d = 3'd2;
    #1 chk("bne_npc", npc, 32'h3008);
    chk("bne_taken", {31'b0, taken_d}, 0);
    step(); chk("bne_pc", pc_f, 32'h3008);

    // bltz on negative rs: 0x300C + 0x10
    br_type_d = 3'd5; rs_d = 32'h8000_0000; pc4_d = 32'h300C; imm26_d = 26'h0004;
    #1 chk("bltz_taken", {31'b0, taken_d}, 1);
    step(); chk("bltz_pc", pc_f, 32'h301C);
    chk("bltz_cnt", {16'b0, br_cnt}, 2);

    // bgtz on zero: not taken; type 7 with equal operands: not taken
    br_type_d = 3'd4; rs_d = 0;
    #1 chk("bgtz0_taken", {31'b0, taken_d}, 0);
    br_type_d = 3'd7; rs_d = 9; rt_d = 9;
    #1 chk("bt7_taken", {31'b0, taken_d}, 0);
    step(); chk("bt7_pc", pc_f, 32'h3020);
    quiet();

    // j under stall: hold, no transfer
    j_d = 1; stall = 1; imm26_d = 26'h0C05; pc4_d = 32'h3010;
    #1 chk("jst_npc", npc, 32'h3020);
    chk("jst_taken", {31'b0, taken_d}, 0);
    step(); chk("jst_pc1", pc_f, 32'h3020);
    step(); chk("jst_pc2", pc_f, 32'h3020);
    stall = 0;
    #1 chk("j_taken", {31'b0, taken_d}, 1);
    step(); chk("j_pc", pc_f, 32'h3014);
    chk("j_cnt", {16'b0, br_cnt}, 3);
    quiet();

    // interrupt beats stall and jr
    int_req = 1; stall = 1; jr_d = 1; rs_d = 32'h3100;
    #1 chk("int_npc", npc, 32'h4180);
    chk("int_taken", {31'b0, taken_d}, 0);
    step(); chk("int_pc", pc_f, 32'h4180);
    chk("int_cnt1", {16'b0, int_cnt}, 1);
    chk("int_brcnt", {16'b0, br_cnt}, 3);
    chk("int_adel", {31'b0, adel_f}, 1);
    quiet();

    // eret return: taken but not counted
    eret_d = 1; epc = 32'h3010;
    #1 chk("eret_taken", {31'b0, taken_d}, 1);
    step(); chk("eret_pc", pc_f, 32'h3010);
    chk("eret_brcnt", {16'b0, br_cnt}, 3);
    quiet();

    // jr targets exercising the address check
    jr_d = 1; rs_d = 32'h3002;
    step(); chk("jr_mis_pc", pc_f, 32'h3002);
    chk("jr_mis_adel", {31'b0, adel_f}, 1);
    rs_d = 32'h4000;
    step(); chk("jr_hi_adel", {31'b0, adel_f}, 1);
    rs_d = 32'h3FFC;
    step(); chk("jr_top_adel", {31'b0, adel_f}, 0);
    chk("jr_cnt", {16'b0, br_cnt}, 6);
    rs_d = 32'h2FFC;
    step(); chk("jr_lo_adel", {31'b0, adel_f}, 1);
    quiet();

    // held interrupt counts every cycle
    int_req = 1;
    step(); step();
    chk("int_hold_pc", pc_f, 32'h4180);
    chk("int_hold_cnt", {16'b0, int_cnt}, 3);

    // reset beats int_req and clears counters
    reset = 1;
    #1 chk("rst_int_npc", npc, 32'h3000);
    step(); chk("rst_int_pc", pc_f, 32'h3000);
    chk("rst_int_cnt", {16'b0, int_cnt}, 0);
    reset = 0; int_req = 0;

    // 20 taken branches: 4-bit counter saturates
    br_type_d = 3'd1; rs_d = 1; rt_d = 1; pc4_d = 32'h3004; imm26_d = 0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", {28'b0, br_cnt_s}, 15);
    chk("sat_wide", {16'b0, br_cnt}, 20);
    chk("sat_pc", pc_f_s, 32'h3004);

    // clear wins over a concurrent taken branch
    cnt_clr = 1;
    step(); chk("clr_cnt", {28'b0, br_cnt_s}, 0);
    chk("clr_wide", {16'b0, br_cnt}, 0);
    quiet();
    step(); chk("clr_hold", {28'b0, br_cnt_s}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
